mul_div_ctrl: RTL and testbench

- FSM sequencer for the iterative RV32M multiplier/divider datapath: shift-add multiply, restoring divide.
- Accepts one operation per start pulse.
- Drives per-cycle datapath controls: load, operand negation, step, add/restore, result fix-up.
- Owns the iteration counter, a syncCounter instance.
- Short-circuits RISC-V divide-by-zero and signed-overflow cases without iterating.

---
 rtl/mul_div_pkg.sv | 47 ++++
 rtl/mul_div_ctrl_sync_counter.sv | 30 +++
 rtl/mul_div_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mul_div_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide sequencer.
package mul_div_pkg;

   typedef enum logic [2:0] {
      F_MUL    = 3'b000,
      F_MULH   = 3'b001,
      F_MULHSU = 3'b010,
      F_MULHU  = 3'b011,
      F_DIV    = 3'b100,
      F_DIVU   = 3'b101,
      F_REM    = 3'b110,
      F_REMU   = 3'b111
   } funct3_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_FIX,
      S_DONE
   } state_e;

   localparam logic [1:0] RESULT_SEL_DP       = 2'b00;
   localparam logic [1:0] RESULT_SEL_ONES     = 2'b01;
   localparam logic [1:0] RESULT_SEL_DIVIDEND = 2'b10;
   localparam logic [1:0] RESULT_SEL_ZERO     = 2'b11;

   function automatic logic is_div(input funct3_e f);
      return f[2];
   endfunction

   function automatic logic is_signed_a(input funct3_e f);
      return (f == F_MUL) || (f == F_MULH) || (f == F_MULHSU) ||
             (f == F_DIV) || (f == F_REM);
   endfunction

   function automatic logic is_signed_b(input funct3_e f);
      return (f == F_MUL) || (f == F_MULH) || (f == F_DIV) || (f == F_REM);
   endfunction

   // Upper product half for MULH*, remainder for REM*.
   function automatic logic is_hi(input funct3_e f);
      return (f == F_MULH) || (f == F_MULHSU) || (f == F_MULHU) ||
             (f == F_REM) || (f == F_REMU);
   endfunction

endpackage

// File: rtl/mul_div_ctrl_sync_counter.sv
// Synchronous up/down counter with clear, load and a terminal-count flag.
module syncCounter #(
   parameter int unsigned           WIDTH  = 6,
   parameter logic [WIDTH-1:0]      THRESH = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             cnt_en,
   input  logic             up_down_n,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (load_en)
         count <= load_val;
      else if (cnt_en)
         count <= up_down_n ? count + 1'b1 : count - 1'b1;
   end

   assign tc = (count == THRESH);

endmodule

// File: rtl/mul_div_ctrl.sv
// Control FSM for the iterative shift-add multiplier / restoring divider datapath.
module mul_div_ctrl
   import mul_div_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [2:0]           funct3_i,
   input  logic                 a_sign_i,
   input  logic                 b_sign_i,
   input  logic                 b_zero_i,
   input  logic                 div_ovf_i,
   input  logic                 mplier_lsb_i,
   input  logic                 partial_neg_i,
   input  logic                 kill_i,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 load_ops_o,
   output logic                 negate_a_o,
   output logic                 negate_b_o,
   output logic                 is_div_o,
   output logic                 step_en_o,
   output logic                 add_en_o,
   output logic                 restore_o,
   output logic                 q_bit_o,
   output logic                 negate_res_o,
   output logic                 hi_sel_o,
   output logic [1:0]           result_sel_o,
   output logic [CNT_WIDTH-1:0] iter_o
);

   generate
      if ((2 ** CNT_WIDTH) <= DATA_WIDTH) begin : g_cnt_width_chk
         $error("mul_div_ctrl: CNT_WIDTH too small to count DATA_WIDTH iterations");
      end
   endgenerate

   localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

   state_e  state_q, state_d;
   funct3_e f3_q;
   logic    a_sign_q, b_sign_q, b_zero_q, div_ovf_q, neg_res_q;
   logic    accept;
   logic    div, sdiv, rem, na, nb, neg_res_d, short_cut;
   logic    cnt_clr, cnt_en, tc;

   assign accept = (state_q == S_IDLE) && start_i && !kill_i;

   always_comb begin
      div       = is_div(f3_q);
      sdiv      = div && is_signed_a(f3_q);
      rem       = div && f3_q[1];
      na        = a_sign_q && is_signed_a(f3_q);
      nb        = b_sign_q && is_signed_b(f3_q);
      neg_res_d = rem ? na : (na ^ nb);
      // RISC-V defines div-by-zero and signed overflow results, so no iterations are needed.
      short_cut = div && (b_zero_q || (sdiv && div_ovf_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         f3_q      <= F_MUL;
         a_sign_q  <= 1'b0;
         b_sign_q  <= 1'b0;
         b_zero_q  <= 1'b0;
         div_ovf_q <= 1'b0;
         neg_res_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            f3_q      <= funct3_e'(funct3_i);
            a_sign_q  <= a_sign_i;
            b_sign_q  <= b_sign_i;
            b_zero_q  <= b_zero_i;
            div_ovf_q <= div_ovf_i;
         end
         if (state_q == S_PREP)
            neg_res_q <= neg_res_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      load_ops_o   = 1'b0;
      negate_a_o   = 1'b0;
      negate_b_o   = 1'b0;
      step_en_o    = 1'b0;
      add_en_o     = 1'b0;
      restore_o    = 1'b0;
      q_bit_o      = 1'b0;
      negate_res_o = 1'b0;
      done_o       = 1'b0;
      case (state_q)
         S_IDLE: if (accept) state_d = S_PREP;
         S_PREP: begin
            load_ops_o = 1'b1;
            negate_a_o = na;
            negate_b_o = nb;
            state_d    = short_cut ? S_DONE : S_RUN;
         end
         S_RUN: begin
            step_en_o = 1'b1;
            add_en_o  = !div && mplier_lsb_i;
            restore_o = div && partial_neg_i;
            q_bit_o   = div && !partial_neg_i;
            if (tc) state_d = S_FIX;
         end
         S_FIX: begin
            negate_res_o = neg_res_q;
            state_d      = S_DONE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (kill_i) begin
         state_d = S_IDLE;
         done_o  = 1'b0;
      end
   end

   always_comb begin
      result_sel_o = RESULT_SEL_DP;
      if (div && b_zero_q)
         result_sel_o = rem ? RESULT_SEL_DIVIDEND : RESULT_SEL_ONES;
      else if (sdiv && div_ovf_q)
         result_sel_o = rem ? RESULT_SEL_ZERO : RESULT_SEL_DIVIDEND;
   end

   assign ready_o  = (state_q == S_IDLE);
   assign busy_o   = !ready_o;
   assign is_div_o = div;
   assign hi_sel_o = is_hi(f3_q);

   // Holding at the last iteration keeps iter_o stable through FIX/DONE.
   assign cnt_clr = (state_q == S_PREP) || kill_i;
   assign cnt_en  = (state_q == S_RUN) && !tc;

   syncCounter #(
      .WIDTH  (CNT_WIDTH),
      .THRESH (LAST_ITER)
   ) u_iter_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (cnt_clr),
      .cnt_en    (cnt_en),
      .up_down_n (1'b1),
      .load_en   (1'b0),
      .load_val  ({CNT_WIDTH{1'b0}}),
      .count     (iter_o),
      .tc        (tc)
   );

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Directed bench for mul_div_ctrl: per-op decode, latency, short-circuits, kill and reset.
module tb_mul_div_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_i, a_sign_i, b_sign_i, b_zero_i, div_ovf_i;
   logic [2:0] funct3_i;
   logic       mplier_lsb_i, partial_neg_i, kill_i;
   logic       ready_o, busy_o, done_o, load_ops_o, negate_a_o, negate_b_o, is_div_o;
   logic       step_en_o, add_en_o, restore_o, q_bit_o, negate_res_o, hi_sel_o;
   logic [1:0] result_sel_o;
   logic [5:0] iter_o;

   int checks = 0;
   int errors = 0;

   mul_div_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .funct3_i      (funct3_i),
      .a_sign_i      (a_sign_i),
      .b_sign_i      (b_sign_i),
      .b_zero_i      (b_zero_i),
      .div_ovf_i     (div_ovf_i),
      .mplier_lsb_i  (mplier_lsb_i),
      .partial_neg_i (partial_neg_i),
      .kill_i        (kill_i),
      .ready_o       (ready_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .load_ops_o    (load_ops_o),
      .negate_a_o    (negate_a_o),
      .negate_b_o    (negate_b_o),
      .is_div_o      (is_div_o),
      .step_en_o     (step_en_o),
      .add_en_o      (add_en_o),
      .restore_o     (restore_o),
      .q_bit_o       (q_bit_o),
      .negate_res_o  (negate_res_o),
      .hi_sel_o      (hi_sel_o),
      .result_sel_o  (result_sel_o),
      .iter_o        (iter_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one op from a start pulse; lat counts edges from the accepting edge to the one that samples done_o.
   task automatic run_op(input logic [2:0] f, input logic as_, input logic bs, input logic bz,
                         input logic ov, input logic hold,
                         output int lat, output int steps, output logic na, output logic nb,
                         output logic nr, output logic hi, output logic [1:0] rs, output int bad);
      logic d;
      @(negedge clk);
      funct3_i = f; a_sign_i = as_; b_sign_i = bs; b_zero_i = bz; div_ovf_i = ov; start_i = 1'b1;
      @(posedge clk);
      lat = 0; steps = 0; na = 0; nb = 0; nr = 0; hi = 0; rs = 0; bad = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (hold) begin
            funct3_i = 3'b001; a_sign_i = ~as_; b_sign_i = ~bs; b_zero_i = ~bz; div_ovf_i = ~ov;
         end else
            start_i = 1'b0;
         partial_neg_i = n[0] ^ n[2];
         mplier_lsb_i  = n[1] ^ n[0];
         #1;
         if (load_ops_o) begin na = negate_a_o; nb = negate_b_o; end
         if (step_en_o) begin
            steps++;
            if (f[2]) begin
               if (q_bit_o !== ~partial_neg_i || restore_o !== partial_neg_i || add_en_o !== 1'b0) bad++;
            end else if (add_en_o !== mplier_lsb_i || restore_o !== 1'b0 || q_bit_o !== 1'b0) bad++;
         end
         if (negate_res_o) nr = 1'b1;
         d = done_o;
         if (d) begin hi = hi_sel_o; rs = result_sel_o; end
         @(posedge clk);
         if (d) begin lat = n; break; end
      end
   endtask

   int         lat, steps, bad, dones;
   logic       na, nb, nr, hi;
   logic [1:0] rs;

   initial begin
      rst_n = 1'b0; start_i = 0; funct3_i = 0; a_sign_i = 0; b_sign_i = 0; b_zero_i = 0;
      div_ovf_i = 0; mplier_lsb_i = 0; partial_neg_i = 0; kill_i = 0;
      #12;
      check("rst_ready", 32'(ready_o), 1);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_iter", 32'(iter_o), 0);
      check("rst_outs", 32'({done_o, load_ops_o, step_en_o, hi_sel_o, result_sel_o, is_div_o}), 0);
      @(negedge clk); rst_n = 1'b1;

      // MULHU: unsigned operands, upper half
      run_op(3'b011, 1, 1, 0, 0, 0, lat, steps, na, nb, nr, hi, rs, bad);
      check("mulhu_lat", lat, 35); check("mulhu_steps", steps, 32);
      check("mulhu_neg", 32'({na, nb, nr}), 0); check("mulhu_hi", 32'(hi), 1);
      check("mulhu_rs", 32'(rs), 0); check("mulhu_add", bad, 0);
      #1; check("mulhu_idle", 32'(ready_o), 1);

      // DIV, negative dividend only
      run_op(3'b100, 1, 0, 0, 0, 0, lat, steps, na, nb, nr, hi, rs, bad);
      check("div_lat", lat, 35); check("div_steps", steps, 32);
      check("div_neg", 32'({na, nb, nr}), 32'b101); check("div_hi", 32'(hi), 0);
      check("div_qbit", bad, 0); check("div_rs", 32'(rs), 0);

      // MUL both negative: result positive
      run_op(3'b000, 1, 1, 0, 0, 0, lat, steps, na, nb, nr, hi, rs, bad);
      check("mul_neg", 32'({na, nb, nr}), 32'b110); check("mul_hi", 32'(hi), 0);
      check("mul_add", bad, 0);

      // MULHSU: B unsigned
      run_op(3'b010, 1, 1, 0, 0, 0, lat, steps, na, nb, nr, hi, rs, bad);
      check("mulhsu_neg", 32'({na, nb, nr}), 32'b101); check("mulhsu_hi", 32'(hi), 1);

      // REM both negative: remainder follows dividend sign
      run_op(3'b110, 1, 1, 0, 0, 0, lat, steps, na, nb, nr, hi, rs, bad);
      check("rem_neg", 32'({na, nb, nr}), 32'b111); check("rem_lat", lat, 35);

      // Divide by zero
      run_op(3'b110, 0, 0, 1, 0, 0, lat, steps, na, nb, nr, hi, rs, bad);
      check("remz_lat", lat, 2); check("remz_steps", steps, 0);
      check("remz_rs", 32'(rs), 2); check("remz_hi", 32'(hi), 1);
      run_op(3'b101, 0, 0, 1, 0, 0, lat, steps, na, nb, nr, hi, rs, bad);
      check("divuz_lat", lat, 2); check("divuz_rs", 32'(rs), 1); check("divuz_hi", 32'(hi), 0);

      // Signed overflow
      run_op(3'b100, 1, 1, 0, 1, 0, lat, steps, na, nb, nr, hi, rs, bad);
      check("divovf_lat", lat, 2); check("divovf_rs", 32'(rs), 2);
      run_op(3'b110, 1, 1, 0, 1, 0, lat, steps, na, nb, nr, hi, rs, bad);
      check("removf_lat", lat, 2); check("removf_rs", 32'(rs), 3);
      run_op(3'b101, 1, 1, 0, 1, 0, lat, steps, na, nb, nr, hi, rs, bad);
      check("divuovf_lat", lat, 35); check("divuovf_steps", steps, 32); check("divuovf_rs", 32'(rs), 0);

      // start held high while busy with changing inputs: ignored, then accepted right after DONE
      run_op(3'b101, 0, 0, 0, 0, 1, lat, steps, na, nb, nr, hi, rs, bad);
      check("hold_lat", lat, 35); check("hold_hi", 32'(hi), 0); check("hold_rs", 32'(rs), 0);
      @(posedge clk); #1;
      check("b2b_load", 32'(load_ops_o), 1); check("b2b_busy", 32'(busy_o), 1);
      @(negedge clk); start_i = 1'b0; kill_i = 1'b1;
      @(posedge clk); #1; check("b2b_kill", 32'(ready_o), 1);
      @(negedge clk); kill_i = 1'b0;

      // kill at iteration 10
      funct3_i = 3'b100; a_sign_i = 0; b_sign_i = 0; b_zero_i = 0; div_ovf_i = 0; start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      for (int i = 0; i < 50 && !(step_en_o && iter_o == 6'd10); i++) @(negedge clk);
      check("kill_reach", 32'(iter_o), 10);
      kill_i = 1'b1;
      @(posedge clk); #1;
      check("kill_idle", 32'(ready_o), 1); check("kill_iter", 32'(iter_o), 0);
      check("kill_done", 32'(done_o), 0);
      @(negedge clk); kill_i = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (done_o) dones++; end
      check("kill_nodone", dones, 0);

      // kill with start in IDLE
      start_i = 1'b1; kill_i = 1'b1;
      @(posedge clk); #1;
      check("killstart_idle", 32'(ready_o), 1); check("killstart_load", 32'(load_ops_o), 0);
      @(negedge clk); start_i = 1'b0; kill_i = 1'b0;

      // async reset at iteration 20
      funct3_i = 3'b111; start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      for (int i = 0; i < 50 && !(step_en_o && iter_o == 6'd20); i++) @(negedge clk);
      check("rst_reach", 32'(iter_o), 20);
      #2; rst_n = 1'b0; #1;
      check("mrst_ready", 32'(ready_o), 1); check("mrst_iter", 32'(iter_o), 0);
      check("mrst_outs", 32'({busy_o, done_o, step_en_o, hi_sel_o, result_sel_o, is_div_o}), 0);
      @(negedge clk); rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 5; i++) begin @(negedge clk); if (done_o) dones++; end
      check("mrst_nodone", dones, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
